// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: default widths, reset vector
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W   = 16;
    localparam int unsigned CPU_INSTR_W  = 16;
    localparam logic [15:0] CPU_RESET_PC = 16'h0000;
    localparam int unsigned PC_INC       = 2;

    typedef enum logic [1:0] {
        START   = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one instruction word with its address and
// fall-through address, plus a valid flag.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned INSTR_W = CPU_INSTR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] next_instr,
    input  logic [ADDR_W-1:0]  next_pc,
    input  logic [ADDR_W-1:0]  next_pc_plus2,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus2
);

    // load wins over clear so a consumed word can be replaced in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus2 <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= next_instr;
            pc       <= next_pc;
            pc_plus2 <= next_pc_plus2;
        end else if (clear) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory requests, a one-word
// hold buffer for stalls and redirect handling feeding the IF/ID register.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = CPU_ADDR_W,
    parameter int unsigned       INSTR_W  = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus2,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus2
);

    fetch_state_t       state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n, pc_inc;
    logic [ADDR_W-1:0]  disc_addr;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc, hold_pc2;
    logic               hold_cap, disc_cap;
    logic               ifid_load, ifid_clear;
    logic [INSTR_W-1:0] ld_instr;
    logic [ADDR_W-1:0]  ld_pc, ld_pc2;

    assign pc_inc    = pc + ADDR_W'(PC_INC);
    assign pc_out    = pc;
    assign pc_plus2  = pc_inc;
    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = (state == DISCARD) ? disc_addr : pc;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_cap   = 1'b0;
        disc_cap   = 1'b0;
        ifid_load  = 1'b0;
        ifid_clear = if_id_valid && !stall;
        ld_instr   = imem_rdata;
        ld_pc      = pc;
        ld_pc2     = pc_inc;
        if (redirect_valid) begin
            ifid_clear = 1'b1;
            pc_n       = redirect_pc & ~ADDR_W'(1);
            unique case (state)
                FETCH: begin
                    // keep the in-flight request at its old address until acked
                    state_n  = imem_ack ? FETCH : DISCARD;
                    disc_cap = !imem_ack;
                end
                DISCARD: state_n = imem_ack ? FETCH : DISCARD;
                default: state_n = FETCH;
            endcase
        end else begin
            unique case (state)
                START: state_n = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        pc_n = pc_inc;
                        if (!if_id_valid || !stall) begin
                            ifid_load = 1'b1;
                        end else begin
                            hold_cap = 1'b1;
                            state_n  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        ld_instr  = hold_instr;
                        ld_pc     = hold_pc;
                        ld_pc2    = hold_pc2;
                        state_n   = FETCH;
                    end
                end
                DISCARD: if (imem_ack) state_n = FETCH;
                default: state_n = START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= START;
            pc         <= RESET_PC;
            disc_addr  <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
            hold_pc2   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (disc_cap) disc_addr <= pc;
            if (hold_cap) begin
                hold_instr <= imem_rdata;
                hold_pc    <= pc;
                hold_pc2   <= pc_inc;
            end
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_if_id (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (ifid_load),
        .clear        (ifid_clear),
        .next_instr   (ld_instr),
        .next_pc      (ld_pc),
        .next_pc_plus2(ld_pc2),
        .valid        (if_id_valid),
        .instr        (if_id_instr),
        .pc           (if_id_pc),
        .pc_plus2     (if_id_pc_plus2)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr ^ 16'hA5A5 and acks
// whenever ack_en is set and a request is outstanding.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] pc_out, pc_plus2;
    logic        if_id_valid;
    logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus2;
    logic        ack_en;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = imem_addr ^ 16'hA5A5;

    fetch_unit #(
        .ADDR_W  (16),
        .INSTR_W (16),
        .RESET_PC(16'h0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc_out        (pc_out),
        .pc_plus2      (pc_plus2),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus2(if_id_pc_plus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; ack_en = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_pc2", pc_plus2, 16'h0002);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instr, 16'h0000);
        chk("rst_ifpc", if_id_pc, 16'h0000);
        chk("rst_ifpc2", if_id_pc_plus2, 16'h0000);

        @(negedge clk); reset_n = 1'b1; ack_en = 1'b1;
        tick();
        chk("start_req", imem_req, 1);
        chk("start_addr", imem_addr, 16'h0000);
        chk("start_valid", if_id_valid, 0);
        tick();
        chk("f1_addr", imem_addr, 16'h0002);
        chk("f1_valid", if_id_valid, 1);
        chk("f1_ifpc", if_id_pc, 16'h0000);
        chk("f1_instr", if_id_instr, 16'hA5A5);
        chk("f1_pc2", pc_plus2, 16'h0004);
        tick();
        chk("f2_addr", imem_addr, 16'h0004);
        chk("f2_ifpc", if_id_pc, 16'h0002);
        chk("f2_instr", if_id_instr, 16'hA5A7);

        // stall for three cycles with an ack landing in the first
        stall = 1'b1;
        tick();
        chk("hold_req", imem_req, 0);
        chk("hold_pc", pc_out, 16'h0006);
        chk("hold_ifpc", if_id_pc, 16'h0002);
        chk("hold_instr", if_id_instr, 16'hA5A7);
        tick();
        chk("hold2_req", imem_req, 0);
        chk("hold2_ifpc", if_id_pc, 16'h0002);
        tick();
        chk("hold3_req", imem_req, 0);
        chk("hold3_valid", if_id_valid, 1);
        stall = 1'b0;
        tick();
        chk("unhold_ifpc", if_id_pc, 16'h0004);
        chk("unhold_instr", if_id_instr, 16'hA5A1);
        chk("unhold_ifpc2", if_id_pc_plus2, 16'h0006);
        chk("unhold_addr", imem_addr, 16'h0006);
        chk("unhold_req", imem_req, 1);
        tick();
        chk("after_ifpc", if_id_pc, 16'h0006);
        chk("after_instr", if_id_instr, 16'hA5A3);

        // redirect with request pending, ack delayed two cycles
        ack_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0101;
        tick();
        redirect_valid = 1'b0;
        chk("disc_req", imem_req, 1);
        chk("disc_addr", imem_addr, 16'h0008);
        chk("disc_pc", pc_out, 16'h0100);
        chk("disc_valid", if_id_valid, 0);
        tick();
        chk("disc2_addr", imem_addr, 16'h0008);
        chk("disc2_valid", if_id_valid, 0);
        ack_en = 1'b1;
        tick();
        chk("stale_valid", if_id_valid, 0);
        chk("redir_addr", imem_addr, 16'h0100);
        chk("redir_req", imem_req, 1);
        tick();
        chk("redir_ifpc", if_id_pc, 16'h0100);
        chk("redir_instr", if_id_instr, 16'hA4A5);
        chk("redir_valid", if_id_valid, 1);

        // redirect coincident with ack: returned word dropped
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        chk("rack_valid", if_id_valid, 0);
        chk("rack_addr", imem_addr, 16'h0200);
        tick();
        chk("rack_ifpc", if_id_pc, 16'h0200);
        chk("rack_instr", if_id_instr, 16'hA7A5);

        // wrap-around at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 16'hFFFE);
        chk("wrap_pc2", pc_plus2, 16'h0000);
        tick();
        chk("wrap_ifpc", if_id_pc, 16'hFFFE);
        chk("wrap_instr", if_id_instr, 16'h5A5B);
        chk("wrap_ifpc2", if_id_pc_plus2, 16'h0000);
        chk("wrap_addr2", imem_addr, 16'h0000);
        tick();
        chk("wrap2_ifpc", if_id_pc, 16'h0000);
        chk("wrap2_instr", if_id_instr, 16'hA5A5);

        // asynchronous reset while in HOLD
        stall = 1'b1;
        tick();
        chk("pre_rst_req", imem_req, 0);
        chk("pre_rst_pc", pc_out, 16'h0004);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req", imem_req, 0);
        chk("arst_pc", pc_out, 16'h0000);
        chk("arst_valid", if_id_valid, 0);
        chk("arst_ifpc", if_id_pc, 16'h0000);
        chk("arst_instr", if_id_instr, 16'h0000);
        stall = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        tick();
        chk("refetch_req", imem_req, 1);
        chk("refetch_addr", imem_addr, 16'h0000);
        tick();
        chk("refetch_ifpc", if_id_pc, 16'h0000);
        chk("refetch_instr", if_id_instr, 16'hA5A5);

        // asynchronous reset with a request outstanding
        chk("mid_req", imem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_arst_req", imem_req, 0);
        chk("mid_arst_valid", if_id_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
